// File: rtl/game_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
package game_pkg;

  localparam int unsigned BOARD_W   = 9;
  localparam int unsigned NUM_LINES = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StXTurn = 2'd1,
    StOTurn = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Squares are row-major: bit 0 is top-left, bit 8 is bottom-right.
  localparam logic [BOARD_W-1:0] WIN_LINES [NUM_LINES] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  function automatic logic is_onehot(input logic [BOARD_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/win_detect.sv
// Flags whether an occupancy map covers any complete row, column or diagonal.
module win_detect
  import game_pkg::*;
(
  input  logic [BOARD_W-1:0] occ_i,
  output logic               line_o
);

  always_comb begin
    line_o = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((occ_i & WIN_LINES[i]) == WIN_LINES[i]) line_o = 1'b1;
    end
  end

endmodule

// File: rtl/game_board.sv
// Turn sequencing, move validation and result tracking for human X versus machine O.
module game_board
  import game_pkg::*;
#(
  parameter bit O_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               xin_valid,
  input  logic [BOARD_W-1:0] xin,
  input  logic [BOARD_W-1:0] oin,
  output logic [BOARD_W-1:0] xbrd,
  output logic [BOARD_W-1:0] obrd,
  output logic [1:0]         state,
  output logic               xin_ready,
  output logic               illegal,
  output logic               win_x,
  output logic               win_o,
  output logic               draw
);

  state_e             state_q, state_d;
  logic [BOARD_W-1:0] xbrd_q, xbrd_d, obrd_q, obrd_d;
  logic               illegal_q, illegal_d;
  logic               win_x_q, win_x_d, win_o_q, win_o_d, draw_q, draw_d;

  logic [BOARD_W-1:0] occ, x_cand, o_cand;
  logic               x_legal, o_legal, x_line, o_line;

  assign occ     = xbrd_q | obrd_q;
  assign x_cand  = xbrd_q | xin;
  assign o_cand  = obrd_q | oin;
  assign x_legal = is_onehot(xin) && ((xin & occ) == '0);
  assign o_legal = is_onehot(oin) && ((oin & occ) == '0);

  // Evaluate the boards as they would look after the candidate placement.
  win_detect u_win_x (
    .occ_i  (x_cand),
    .line_o (x_line)
  );

  win_detect u_win_o (
    .occ_i  (o_cand),
    .line_o (o_line)
  );

  always_comb begin
    state_d   = state_q;
    xbrd_d    = xbrd_q;
    obrd_d    = obrd_q;
    illegal_d = 1'b0;
    win_x_d   = win_x_q;
    win_o_d   = win_o_q;
    draw_d    = draw_q;
    if (start) begin
      state_d = O_FIRST ? StOTurn : StXTurn;
      xbrd_d  = '0;
      obrd_d  = '0;
      win_x_d = 1'b0;
      win_o_d = 1'b0;
      draw_d  = 1'b0;
    end else begin
      unique case (state_q)
        StXTurn: begin
          if (xin_valid) begin
            if (x_legal) begin
              xbrd_d = x_cand;
              if (x_line) begin
                win_x_d = 1'b1;
                state_d = StDone;
              end else if (&(x_cand | obrd_q)) begin
                draw_d  = 1'b1;
                state_d = StDone;
              end else begin
                state_d = StOTurn;
              end
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        StOTurn: begin
          if (o_legal) begin
            obrd_d = o_cand;
            if (o_line) begin
              win_o_d = 1'b1;
              state_d = StDone;
            end else if (&(xbrd_q | o_cand)) begin
              draw_d  = 1'b1;
              state_d = StDone;
            end else begin
              state_d = StXTurn;
            end
          end else begin
            // A broken move selector ends the game rather than corrupting the board.
            draw_d  = 1'b1;
            state_d = StDone;
          end
        end
        StIdle, StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      xbrd_q    <= '0;
      obrd_q    <= '0;
      illegal_q <= 1'b0;
      win_x_q   <= 1'b0;
      win_o_q   <= 1'b0;
      draw_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      xbrd_q    <= xbrd_d;
      obrd_q    <= obrd_d;
      illegal_q <= illegal_d;
      win_x_q   <= win_x_d;
      win_o_q   <= win_o_d;
      draw_q    <= draw_d;
    end
  end

  assign xbrd      = xbrd_q;
  assign obrd      = obrd_q;
  assign state     = state_q;
  assign xin_ready = (state_q == StXTurn);
  assign illegal   = illegal_q;
  assign win_x     = win_x_q;
  assign win_o     = win_o_q;
  assign draw      = draw_q;

endmodule

// File: tb/tb_game_board.sv
// Random and directed games against a square-by-square reference model of the board.
module tb_game_board;
  import game_pkg::*;

  logic       clk;
  logic       rst_n, start, xin_valid;
  logic [8:0] xin, oin, xbrd, obrd;
  logic [1:0] state;
  logic       xin_ready, illegal, win_x, win_o, draw;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Environment stand-in for the machine's move-select chain.
  bit         o_force_en = 1'b0;
  logic [8:0] o_force    = '0;
  int         o_mode     = 0;

  // Reference model: one cell per square, 0 empty, 1 X, 2 O.
  int     m_cell [9];
  state_e m_st;
  bit     m_ill, m_wx, m_wo, m_dr;
  int     lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                           '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  game_board #(.O_FIRST(1'b0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .xin_valid (xin_valid),
    .xin       (xin),
    .oin       (oin),
    .xbrd      (xbrd),
    .obrd      (obrd),
    .state     (state),
    .xin_ready (xin_ready),
    .illegal   (illegal),
    .win_x     (win_x),
    .win_o     (win_o),
    .draw      (draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] o_pick(input int mode, input logic [8:0] xb, input logic [8:0] ob);
    logic [8:0] occ;
    logic [8:0] r;
    occ = xb | ob;
    r   = '0;
    case (mode)
      0: for (int i = 8; i >= 0; i--) if (!occ[i]) r = 9'(1) << i;
      1: for (int i = 0; i < 9; i++) if (!occ[i]) r = 9'(1) << i;
      2: r = '0;
      default: for (int i = 8; i >= 0; i--) if (occ[i]) r = 9'(1) << i;
    endcase
    return r;
  endfunction

  always_comb oin = o_force_en ? o_force : o_pick(o_mode, xbrd, obrd);

  function automatic logic [8:0] m_bits(input int who);
    logic [8:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) if (m_cell[i] == who) b[i] = 1'b1;
    return b;
  endfunction

  function automatic bit m_has_line(input int who);
    for (int l = 0; l < 8; l++)
      if (m_cell[lines[l][0]] == who && m_cell[lines[l][1]] == who && m_cell[lines[l][2]] == who)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_full();
    for (int i = 0; i < 9; i++) if (m_cell[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Place a single mark for `who` if the move is one empty square; returns 0 otherwise.
  function automatic bit m_place(input int who, input logic [8:0] mv);
    int sq;
    if ($countones(mv) != 1) return 1'b0;
    sq = 0;
    for (int i = 0; i < 9; i++) if (mv[i]) sq = i;
    if (m_cell[sq] != 0) return 1'b0;
    m_cell[sq] = who;
    return 1'b1;
  endfunction

  task automatic m_after_move(input int who);
    if (m_has_line(who)) begin
      if (who == 1) m_wx = 1'b1;
      else m_wo = 1'b1;
      m_st = StDone;
    end else if (m_full()) begin
      m_dr = 1'b1;
      m_st = StDone;
    end else begin
      m_st = (who == 1) ? StOTurn : StXTurn;
    end
  endtask

  task automatic model_step(input bit r, input bit s, input bit v, input logic [8:0] x,
                            input logic [8:0] o);
    if (!r) begin
      foreach (m_cell[i]) m_cell[i] = 0;
      m_st = StIdle;
      {m_ill, m_wx, m_wo, m_dr} = '0;
    end else begin
      m_ill = 1'b0;
      if (s) begin
        foreach (m_cell[i]) m_cell[i] = 0;
        {m_wx, m_wo, m_dr} = '0;
        m_st = StXTurn;
      end else if (m_st == StXTurn) begin
        if (v) begin
          if (m_place(1, x)) m_after_move(1);
          else m_ill = 1'b1;
        end
      end else if (m_st == StOTurn) begin
        if (m_place(2, o)) m_after_move(2);
        else begin
          m_dr = 1'b1;
          m_st = StDone;
        end
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".state"},   16'(state),     16'(m_st));
    check_eq({tag, ".xbrd"},    16'(xbrd),      16'(m_bits(1)));
    check_eq({tag, ".obrd"},    16'(obrd),      16'(m_bits(2)));
    check_eq({tag, ".ready"},   16'(xin_ready), 16'(m_st == StXTurn));
    check_eq({tag, ".illegal"}, 16'(illegal),   16'(m_ill));
    check_eq({tag, ".flags"},   16'({win_x, win_o, draw}), 16'({m_wx, m_wo, m_dr}));
  endtask

  task automatic cycle(input bit r, input bit s, input bit v, input logic [8:0] x,
                       input string tag);
    logic [8:0] o_model;
    rst_n = r; start = s; xin_valid = v; xin = x;
    #1;
    o_model = o_force_en ? o_force : o_pick(o_mode, m_bits(1), m_bits(2));
    model_step(r, s, v, x, o_model);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Scripted game: X plays xs[i], O answers with os[i] (forced) until a result.
  task automatic play(input logic [8:0] xs [5], input logic [8:0] os [4], input string tag);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, xs[i], {tag, ".x"});
      if (m_st == StDone) break;
      o_force_en = 1'b1;
      o_force    = os[i];
      cycle(1, 0, 0, '0, {tag, ".o"});
      o_force_en = 1'b0;
      if (m_st == StDone) break;
    end
  endtask

  initial begin
    logic [8:0] xs [5];
    logic [8:0] os [4];
    logic [8:0] one;
    logic [8:0] x;
    bit         r, s, v;
    int         sq;

    one = 9'd1;
    rst_n = 1'b0; start = 1'b0; xin_valid = 1'b0; xin = '0;
    foreach (m_cell[i]) m_cell[i] = 0;
    m_st = StIdle;
    {m_ill, m_wx, m_wo, m_dr} = '0;

    // Reset wins over start; first start after reset is honoured.
    cycle(0, 1, 1, 9'h001, "reset");
    cycle(1, 0, 0, '0, "idle");
    cycle(1, 1, 1, 9'h001, "start");

    // First X move, then forced O reply on the centre two edges later.
    o_force_en = 1'b1; o_force = 9'h010;
    cycle(1, 0, 1, 9'h001, "x_first");
    cycle(1, 0, 0, '0, "o_reply");
    o_force_en = 1'b0;

    cycle(1, 0, 1, 9'h010, "occupied");
    cycle(1, 0, 0, '0, "ill_drop");
    cycle(1, 0, 1, 9'h003, "not_onehot");
    cycle(1, 0, 1, 9'h000, "zero_move");

    // X wins on the top row; later offers are ignored.
    cycle(1, 1, 0, '0, "restart");
    xs = '{9'h001, 9'h002, 9'h004, 9'h000, 9'h000};
    os = '{9'h008, 9'h010, 9'h000, 9'h000};
    play(xs, os, "xwin");
    cycle(1, 0, 1, 9'h100, "done_ignore");

    // Full board without a line.
    cycle(1, 1, 0, '0, "restart2");
    xs = '{9'h001, 9'h004, 9'h010, 9'h020, 9'h080};
    os = '{9'h002, 9'h008, 9'h040, 9'h100};
    play(xs, os, "draw");

    // Defensive end on a zero O move.
    cycle(1, 1, 0, '0, "restart3");
    o_force_en = 1'b1; o_force = 9'h000;
    cycle(1, 0, 1, 9'h001, "bad_o_x");
    cycle(1, 0, 0, '0, "bad_o");
    o_force_en = 1'b0;

    // Start mid-game with simultaneous offer, then reset during O_TURN.
    cycle(1, 1, 0, '0, "restart4");
    cycle(1, 0, 1, 9'h100, "mid_x");
    cycle(1, 0, 1, 9'h001, "mid_o");
    cycle(1, 1, 1, 9'h001, "abort");
    cycle(1, 0, 1, 9'h002, "abort_x");
    cycle(0, 0, 0, '0, "rst_in_o");

    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 79) != 0);
      if (m_st == StIdle || m_st == StDone) s = ($urandom_range(0, 2) == 0);
      else s = ($urandom_range(0, 49) == 0);
      if (s) o_mode = ($urandom_range(0, 9) == 0) ? 2 + $urandom_range(0, 1) : $urandom_range(0, 1);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        x = 9'($urandom);
      end else begin
        sq = $urandom_range(0, 8);
        for (int k = 0; k < 9; k++)
          if (m_cell[(sq + k) % 9] == 0 && $urandom_range(0, 1) == 0) begin
            sq = (sq + k) % 9;
            break;
          end
        x = one << sq;
      end
      cycle(r, s, v, x, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_board.md
GAME_BOARD -- requirements
Module: game_board

Interface
REQ-001 Parameter: O_FIRST, default 0, 1 = machine (O) moves first after start.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  single-cycle pulse; clears board, begins new game.
REQ-005 xin_valid  input  1  human (X) move offered this cycle.
REQ-006 xin  input  9  human move, one-hot square index 0..8, row-major.
REQ-007 oin  input  9  machine move, one-hot, from combinational move-select chain driven by xbrd/obrd.
REQ-008 xbrd  output  9  registered X occupancy.
REQ-009 obrd  output  9  registered O occupancy.
REQ-010 state  output  2  current FSM state (encoding from package).
REQ-011 xin_ready  output  1  high only in X_TURN.
REQ-012 illegal  output  1  one-cycle pulse on rejected X move.
REQ-013 win_x, win_o, draw  output  1 each  game result, held in DONE.

Function
REQ-014 FSM states: IDLE, X_TURN, O_TURN, DONE.
REQ-015 IDLE: wait for start; start -> O_TURN if O_FIRST else X_TURN; boards cleared same edge.
REQ-016 X_TURN: accept when xin_valid & xin one-hot & (xin & (xbrd|obrd))==0; xbrd |= xin at that edge.
REQ-017 X_TURN rejected offer (not one-hot or occupied): illegal pulses next cycle, boards unchanged, stay X_TURN.
REQ-018 O_TURN lasts exactly one cycle: obrd |= oin at its closing edge; latency from accepted X move to O placement is 2 edges.
REQ-019 O_TURN with oin zero, not one-hot or overlapping occupied squares: obrd unchanged, draw asserted, go to DONE (defensive).
REQ-020 After each placement, evaluate updated board: mover has a complete line (3 rows, 3 cols, 2 diagonals) -> DONE with that mover's win flag; else all 9 squares occupied -> DONE with draw; else hand turn to other player.
REQ-021 Result flags registered, mutually exclusive, set on DONE entry, held until start or reset.
REQ-022 DONE: ignore xin_valid; start -> clear boards and flags, re-enter per REQ-015.
REQ-023 start in X_TURN or O_TURN aborts game and restarts identically; start has priority over simultaneous xin_valid.
REQ-024 xin_ready combinational from state; xin may change freely when xin_ready low.

Reset
REQ-025 rst_n low at a rising edge: state=IDLE, xbrd=obrd=0, win_x=win_o=draw=illegal=0, regardless of current state or concurrent inputs.
REQ-026 Reset overrides start; first start is honoured on the first edge with rst_n high.

Structure
REQ-027 Package game_pkg holds: state enum, 8-entry win-line mask constant table (9-bit masks), BOARD_W=9.
REQ-028 One sub-module win_detect: 9-bit occupancy in, 1-bit "has a line" out, purely combinational, instantiated twice (X, O).
REQ-029 All state and board registers in one clocked process; next-state logic combinational.

Verification
REQ-030 Reset then start, O_FIRST=0: state=X_TURN, xbrd=obrd=0, xin_ready=1.
REQ-031 X plays 0x001, oin=0x010: xbrd=0x001 after edge 1, obrd=0x010 after edge 2, back in X_TURN.
REQ-032 X plays 0x010 onto occupied centre: illegal=1 one cycle, boards unchanged; xin=0x003: illegal=1.
REQ-033 X moves 0x001,0x002,0x004 with O on 0x008,0x010: win_x=1 in DONE, win_o=draw=0; further xin_valid ignored.
REQ-034 Full board with no line (xbrd=0x0B5... sequence ending X on last square, final 0x1FF occupancy): draw=1.
REQ-035 start mid-game and rst_n low mid-O_TURN: boards cleared, flags 0, state per REQ-015/REQ-025.
